mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering CPU requests after a
// fixed number of wait cycles.
//
// Parameters
//   DEPTH_LOG2  : log2 of the number of 32-bit words (storage depth)
//   WAIT_CYCLES : wait cycles between accept and response (0..15)
//
// Ports
//   clk              : clock, all logic on the rising edge
//   rst              : synchronous, active-low reset
//   mem_req          : request strobe, sampled only in IDLE
//   memory_addr      : byte address
//   data_to_memory   : write data
//   write_to_memory  : 1 = write, 0 = read
//   data_from_memory : read data, held until the next read response
//   mem_ready        : one-cycle response strobe
//   memory_error     : error flag, meaningful only with mem_ready
//
// Build option
//   MEM_RESPONDER_ALIGN_CHECK_EN : when defined, a byte address that is not
//   word aligned is answered with an error as well.

module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [31:0] memory_addr,
  input  logic [31:0] data_to_memory,
  input  logic        write_to_memory,
  output logic [31:0] data_from_memory,
  output logic        mem_ready,
  output logic        memory_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  // With WAIT_CYCLES = 0 the response is registered on the accept edge
  // itself, before the capture registers hold the request, so the
  // decision logic looks at the live bus while IDLE.
  logic [31:0]           src_addr_d;
  logic                  src_we_d;
  logic [DEPTH_LOG2-1:0] idx_d;
  logic                  range_err_d;
  logic                  align_err_d;
  logic                  err_d;
  logic [31:0]           rdata_d;

  always_comb begin
    src_addr_d = addr_q;
    src_we_d   = we_q;
    if (state_q == IDLE) begin
      src_addr_d = memory_addr;
      src_we_d   = write_to_memory;
    end
  end

  assign idx_d       = src_addr_d[DEPTH_LOG2+1:2];
  assign range_err_d = |(src_addr_d >> (DEPTH_LOG2 + 2));

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign align_err_d = |src_addr_d[1:0];
`else
  logic unused_lsb;
  assign unused_lsb  = ^src_addr_d[1:0];
  assign align_err_d = 1'b0;
`endif

  assign err_d = range_err_d | align_err_d;

  // Writes leave the read-data register untouched.
  always_comb begin
    rdata_d = rdata_q;
    if (!src_we_d) begin
      rdata_d = err_d ? 32'h0 : mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (mem_req) begin
            addr_q  <= memory_addr;
            wdata_q <= data_to_memory;
            we_q    <= write_to_memory;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= err_d;
              rdata_q <= rdata_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= err_d;
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Commit on the edge that ends RESP; a reset on that edge drops it.
  // Storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst && state_q == RESP && we_q && !err_q) begin
      mem_q[idx_d] <= wdata_q;
    end
  end

  assign data_from_memory = rdata_q;
  assign mem_ready        = ready_q;
  assign memory_error     = err_q;

endmodule
